fft_np_ctrl: RTL
================

Name: fft_np_ctrl

Overview:
- Parametrised controller for a radix-2 N-point FFT datapath, where N = 2^LOG2N.
- Paces serial sample capture into the serial-to-parallel buffer with a valid/ready handshake.
- For each completed frame, launches one-cycle enable pulses down the LOG2N butterfly stages and signals frame completion.
- Supports single-shot and continuous (back-to-back frame) operation, plus synchronous flush. Sits between the sample source and the S2P and butterfly stage blocks.

Parameters:
- LOG2N, 3, log2 of FFT size; N = 2^LOG2N; legal range 1..10.
- STAGE_LAT, 1, cycles between successive stage enables (butterfly pipeline depth); legal range ≥1.
- FCNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  arms capture; pulse or level, sampled in IDLE only.
- cont_mode  in  1  1 = re-arm automatically after each frame; 0 = single frame.
- flush  in  1  synchronous clear of capture and in-flight stage tokens.
- in_valid  in  1  source has a sample.
- in_ready  out  1  controller accepts a sample (registered).
- en_s2p  out  1  write strobe to S2P; = in_valid & in_ready (combinational).
- s2p_addr  out  LOG2N  S2P write index of the current sample.
- en_stage  out  LOG2N  per-stage one-cycle enable; bit s drives stage s.
- frame_done  out  1  one-cycle pulse when the last stage of a frame has completed.
- busy  out  1  capture active or any stage token in flight.
- frame_cnt  out  FCNT_W  completed-frame count, wraps modulo 2^FCNT_W.

Behaviour:
- Reset values: in_ready=0, s2p_addr=0, en_stage=0, frame_done=0, busy=0, frame_cnt=0. FSM is in IDLE and the token shift register is clear.
- FSM states:
  - IDLE: in_ready=0. On start=1 (and flush=0), go to CAPTURE and set in_ready=1 from the next cycle.
  - CAPTURE: in_ready=1.
    - Each cycle with in_valid=1: accept the sample and increment s2p_addr.
    - On acceptance with s2p_addr==N-1: s2p_addr wraps to 0 and a launch token is injected.
    - After the wrap: if cont_mode=1, stay in CAPTURE with in_ready held 1 (no bubble); otherwise go to IDLE with in_ready=0 the next cycle.
    - cont_mode is sampled only at the N-th acceptance.
- Gaps: in_valid=0 cycles inside a frame stall s2p_addr. There is no timeout.
- Stage pipeline:
  - A token shift register of length LOG2N*STAGE_LAT+1 is used.
  - With the N-th acceptance at edge E: en_stage[0]=1 for the cycle after E.
  - en_stage[s]=1 exactly s*STAGE_LAT cycles after en_stage[0].
  - frame_done=1 exactly STAGE_LAT cycles after en_stage[LOG2N-1].
  - Latency, N-th acceptance to frame_done: LOG2N*STAGE_LAT+1 cycles.
- Multiple frames may be in flight at once: tokens shift independently, and frames are at least N cycles apart by construction. en_stage bits from different frames may be high in the same cycle.
- frame_cnt increments on the same edge at which frame_done goes high, i.e. frame_cnt shows the new value while frame_done is high.
- busy = (state==CAPTURE) | (any token bit set). busy is registered-consistent with the outputs.
- flush, which has priority over everything except reset:
  - On the next edge: state=IDLE, s2p_addr=0, in_ready=0, and all tokens are cleared, so no further en_stage or frame_done from in-flight frames.
  - frame_cnt is not cleared.
  - A sample presented in the flush cycle is not accepted, because en_s2p is gated by ~flush.
- Start while not IDLE is ignored.
- Start and flush in the same cycle: flush wins and the FSM stays in IDLE.
- Asynchronous reset mid-frame: all state is cleared immediately and partial frames are discarded.

Decomposition:
- Shared package fft_pkg holds:
  - the FSM state enum (IDLE, CAPTURE);
  - the default LOG2N/STAGE_LAT constants;
  - the function computing token length LOG2N*STAGE_LAT+1.
- One natural sub-module: fft_stage_token_pipe. It is a parametrised shift register with inject input, synchronous clear, per-stage tap outputs and a done tap, instantiated once.

Test Plan:
- LOG2N=3, STAGE_LAT=1, cont_mode=0: start, then 8 contiguous valid samples.
  - Required: s2p_addr 0..7.
  - en_stage[0] in the cycle after the 8th accept, en_stage[1] +1, en_stage[2] +2, frame_done +3.
  - frame_cnt=1, then busy=0 and in_ready=0.
- Same configuration with in_valid low in cycles 3 and 6 of the frame: addresses stall, no sample is lost, the schedule shifts by 2 cycles, and frame_done occurs exactly once.
- cont_mode=1, 3 frames back-to-back (24 contiguous samples): in_ready stays 1 throughout, there are 3 frame_done pulses 8 cycles apart, and frame_cnt=3.
- STAGE_LAT=3: en_stage pulses are spaced 3 cycles apart and frame_done comes 10 cycles after the 8th accept.
- flush asserted while en_stage[1] is high for a frame and capture of the next frame is at addr 4: no further en_stage or frame_done, s2p_addr=0, state IDLE, frame_cnt unchanged.
- reset_n dropped mid-capture, then released and start given: all outputs are 0 during reset, and the next frame starts at s2p_addr=0 with correct timing.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type, default sizing and token-length helper for the FFT controller
package fft_pkg;
  typedef enum logic {IDLE, CAPTURE} state_t;
  localparam int DEF_LOG2N = 3;
  localparam int DEF_STAGE_LAT = 1;
  // One slot per stage step plus the trailing done slot
  function automatic int tok_len(input int log2n, input int stage_lat);
    return log2n * stage_lat + 1;
  endfunction
endpackage

// File: rtl/fft_np_ctrl_if.sv
// fft_np_ctrl_if: control/handshake bundle between sample source, controller and FFT datapath
//   master: drives start/cont_mode/flush/in_valid, observes controller outputs
//   slave : the controller (in_ready, en_s2p, s2p_addr, en_stage, frame_done, busy, frame_cnt)
interface fft_np_ctrl_if import fft_pkg::*; #(
  parameter int LOG2N = DEF_LOG2N,
  parameter int FCNT_W = 8
);
  logic start, cont_mode, flush, in_valid;
  logic in_ready, en_s2p, frame_done, busy;
  logic [LOG2N-1:0] s2p_addr, en_stage;
  logic [FCNT_W-1:0] frame_cnt;
  modport master (output start, cont_mode, flush, in_valid,
                  input in_ready, en_s2p, s2p_addr, en_stage, frame_done, busy, frame_cnt);
  modport slave (input start, cont_mode, flush, in_valid,
                 output in_ready, en_s2p, s2p_addr, en_stage, frame_done, busy, frame_cnt);
endinterface

// File: rtl/fft_stage_token_pipe.sv
// fft_stage_token_pipe: launch-token shift register feeding the butterfly stage enables
//   inject   : token enters slot 0 (first stage enable next cycle)
//   clr      : synchronous clear of all in-flight tokens (wins over inject)
//   taps[s]  : stage s enable, STAGE_LAT slots apart
//   done     : last slot, frame completion pulse
//   done_nxt : a token will reach the done slot on the next edge
//   any      : at least one token in flight
module fft_stage_token_pipe import fft_pkg::*; #(
  parameter int LOG2N = DEF_LOG2N,
  parameter int STAGE_LAT = DEF_STAGE_LAT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inject,
  input  logic             clr,
  output logic [LOG2N-1:0] taps,
  output logic             done,
  output logic             done_nxt,
  output logic             any
);
  localparam int L = tok_len(LOG2N, STAGE_LAT);
  logic [L-1:0] tok;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tok <= '0;
    else tok <= clr ? '0 : {tok[L-2:0], inject};
  genvar s;
  for (s = 0; s < LOG2N; s++) begin : g_tap
    assign taps[s] = tok[s*STAGE_LAT];
  end
  assign done = tok[L-1];
  assign done_nxt = tok[L-2] & ~clr;
  assign any = |tok;
endmodule

// File: rtl/fft_np_ctrl.sv
// fft_np_ctrl: radix-2 N-point FFT controller; paces S2P capture and launches stage enables per frame
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : start/cont_mode/flush/in_valid in; in_ready, en_s2p, s2p_addr,
//                  en_stage, frame_done, busy, frame_cnt out
module fft_np_ctrl import fft_pkg::*; #(
  parameter int LOG2N = DEF_LOG2N,
  parameter int STAGE_LAT = DEF_STAGE_LAT,
  parameter int FCNT_W = 8
) (
  input logic         clk,
  input logic         reset_n,
  fft_np_ctrl_if.slave bus
);
  state_t state, state_nxt;
  logic [LOG2N-1:0] addr;
  logic [FCNT_W-1:0] fcnt;
  logic last, done_nxt, tok_any;
  // in_ready comes straight from the state flop, so it is registered
  assign bus.in_ready = state == CAPTURE;
  assign bus.en_s2p = bus.in_valid & bus.in_ready & ~bus.flush;
  assign last = bus.en_s2p & (&addr);
  always_comb begin
    state_nxt = state;
    state_nxt = bus.flush ? IDLE :
                (state == IDLE) ? (bus.start ? CAPTURE : IDLE) :
                (last & ~bus.cont_mode) ? IDLE : CAPTURE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      fcnt <= '0;
    end else begin
      state <= state_nxt;
      addr <= bus.flush ? '0 : addr + LOG2N'(bus.en_s2p);
      fcnt <= fcnt + FCNT_W'(done_nxt);
    end
  fft_stage_token_pipe #(.LOG2N(LOG2N), .STAGE_LAT(STAGE_LAT)) u_pipe (
    .clk(clk), .reset_n(reset_n), .inject(last), .clr(bus.flush),
    .taps(bus.en_stage), .done(bus.frame_done), .done_nxt(done_nxt), .any(tok_any)
  );
  assign bus.s2p_addr = addr;
  assign bus.frame_cnt = fcnt;
  assign bus.busy = bus.in_ready | tok_any;
endmodule
